// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED ring/bar sequencer.
//   state_t   - top-level mode (IDLE, SWEEP, FLASH, KO)
//   dir_t     - sweep travel direction
//   LED_W     - number of LEDs on the bar
//   LED_OFF / LED_ALL - whole-bar patterns
//   pos_to_led - one-hot LED pattern for a sweep position
package led_seq_pkg;

  localparam int LED_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FLASH = 2'd2,
    KO    = 2'd3
  } state_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  localparam logic [LED_W-1:0] LED_OFF  = '0;
  localparam logic [LED_W-1:0] LED_ALL  = '1;
  localparam logic [2:0]       POS_LAST = 3'(LED_W - 1);

  function automatic logic [LED_W-1:0] pos_to_led(input logic [2:0] pos);
    pos_to_led = LED_W'(1) << pos;
  endfunction

endpackage

// File: rtl/led_sequencer_tick_divider.sv
// tick_divider: prescaler producing a one-cycle tick every div cycles.
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - synchronous restart; the cycle after clear is count 0
//   div        - divide value (>= 1), may change only together with clear
//   tick       - high during the last cycle of each div-cycle period
module tick_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt_reg;

  // ">=" keeps the counter from running away if div ever shrinks mid-count.
  assign tick = (cnt_reg >= div - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: mode controller for the 5-LED bar.
//   clk, rst_n - clock and asynchronous active-low reset
//   start      - pulse, begin sweep from IDLE
//   stop       - pulse, return to IDLE from any state
//   hit_req    - pulse, flash the bar (accepted only while sweeping)
//   ko_req     - pulse, light the bar steadily (from SWEEP or FLASH)
//   led        - registered LED drive, bit 0 is the first LED
//   busy       - registered, high whenever not IDLE
//   hit_ack    - registered one-cycle pulse on FLASH entry
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int STEP_DIV    = 4,
  parameter int FLASH_DIV   = 4,
  parameter int FLASH_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hit_req,
  input  logic             ko_req,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             hit_ack
);

  localparam int MAX_DIV = (STEP_DIV > FLASH_DIV) ? STEP_DIV : FLASH_DIV;
  localparam int DW      = $clog2(MAX_DIV) + 1;
  localparam int PW      = $clog2(2 * FLASH_COUNT);
  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * FLASH_COUNT - 1);

  state_t           state_reg, state_next;
  logic [2:0]       pos_reg, pos_next;
  dir_t             dir_reg, dir_next;
  logic [PW-1:0]    phase_reg, phase_next;
  logic [LED_W-1:0] led_next;
  logic             busy_next;
  logic             hit_ack_next;

  logic             tick;
  logic             div_clear;
  logic [DW-1:0]    div_sel;

  // The divider restarts on every state change, so div_sel only needs to
  // reflect the state currently being timed.
  assign div_sel   = (state_reg == FLASH) ? DW'(FLASH_DIV) : DW'(STEP_DIV);
  assign div_clear = (state_next != state_reg);

  tick_divider #(
    .W (DW)
  ) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (div_clear),
    .div   (div_sel),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pos_reg   <= 3'd0;
      dir_reg   <= DIR_UP;
      phase_reg <= '0;
      led       <= LED_OFF;
      busy      <= 1'b0;
      hit_ack   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      dir_reg   <= dir_next;
      phase_reg <= phase_next;
      led       <= led_next;
      busy      <= busy_next;
      hit_ack   <= hit_ack_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pos_next     = pos_reg;
    dir_next     = dir_reg;
    phase_next   = phase_reg;
    hit_ack_next = 1'b0;

    if (stop) begin
      // stop outranks everything and discards the sweep context.
      state_next = IDLE;
      pos_next   = 3'd0;
      dir_next   = DIR_UP;
      phase_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = SWEEP;
            pos_next   = 3'd0;
            dir_next   = DIR_UP;
          end
        end
        SWEEP: begin
          if (ko_req) begin
            state_next = KO;
            phase_next = '0;
          end else if (hit_req) begin
            state_next   = FLASH;
            phase_next   = '0;
            hit_ack_next = 1'b1;
          end else if (tick) begin
            // Bounce turns around in a single step, so the end positions
            // dwell no longer than the middle ones.
            if (dir_reg == DIR_UP) begin
              if (pos_reg == POS_LAST) begin
                pos_next = pos_reg - 3'd1;
                dir_next = DIR_DOWN;
              end else begin
                pos_next = pos_reg + 3'd1;
              end
            end else begin
              if (pos_reg == 3'd0) begin
                pos_next = 3'd1;
                dir_next = DIR_UP;
              end else begin
                pos_next = pos_reg - 3'd1;
              end
            end
          end
        end
        FLASH: begin
          if (ko_req) begin
            state_next = KO;
            phase_next = '0;
          end else if (tick) begin
            if (phase_reg == PHASE_LAST) begin
              // pos/dir were left untouched, so the sweep resumes in place.
              state_next = SWEEP;
              phase_next = '0;
            end else begin
              phase_next = phase_reg + PW'(1);
            end
          end
        end
        KO: begin
          // Only stop leaves KO; handled above.
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    // Outputs are derived from the next state so they are registered
    // alongside it and appear right after the deciding edge.
    led_next = LED_OFF;
    case (state_next)
      IDLE:    led_next = LED_OFF;
      SWEEP:   led_next = pos_to_led(pos_next);
      FLASH:   led_next = phase_next[0] ? LED_OFF : LED_ALL;
      KO:      led_next = LED_ALL;
      default: led_next = LED_OFF;
    endcase
    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       hit_req = 1'b0;
  logic       ko_req = 1'b0;
  logic [4:0] led;
  logic       busy;
  logic       hit_ack;

  always #5 clk = ~clk;

  led_sequencer #(
    .STEP_DIV    (4),
    .FLASH_DIV   (4),
    .FLASH_COUNT (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .hit_req (hit_req),
    .ko_req  (ko_req),
    .led     (led),
    .busy    (busy),
    .hit_ack (hit_ack)
  );

  // request bits: {stop, ko_req, hit_req, start}
  localparam logic [3:0] R_NONE  = 4'b0000;
  localparam logic [3:0] R_START = 4'b0001;
  localparam logic [3:0] R_HIT   = 4'b0010;
  localparam logic [3:0] R_KO    = 4'b0100;
  localparam logic [3:0] R_STOP  = 4'b1000;

  localparam logic [4:0] OFF = 5'b00000;
  localparam logic [4:0] ALL = 5'b11111;

  typedef struct {
    logic [3:0] req;   // applied on the first cycle of the record only
    int         n;     // number of cycles the expectation holds
    logic [4:0] led;
    logic       busy;
    logic       ack;
  } vec_t;

  typedef struct {
    logic [4:0] led;
    logic       busy;
    logic       ack;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(logic [3:0] req, int n, logic [4:0] l, logic b, logic a);
    vec_t v;
    v.req = req; v.n = n; v.led = l; v.busy = b; v.ack = a;
    vecs.push_back(v);
  endfunction

  task automatic check(string tag, logic [4:0] l, logic b, logic a);
    total++;
    if (led !== l || busy !== b || hit_ack !== a) begin
      bad++;
      $display("FAIL %s: got led=%b busy=%b ack=%b, want led=%b busy=%b ack=%b",
               tag, led, busy, hit_ack, l, b, a);
    end
  endtask

  // Called at a negedge: drive requests for the next posedge, push the
  // expected post-edge outputs, and compare them at the following negedge.
  task automatic drive_cycle(logic [3:0] req, logic [4:0] l, logic b, logic a, string tag);
    exp_t e;
    exp_t got;
    {stop, ko_req, hit_req, start} = req;
    e.led = l; e.busy = b; e.ack = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    {stop, ko_req, hit_req, start} = R_NONE;
    @(negedge clk);
    got = sb.pop_front();
    check(tag, got.led, got.busy, got.ack);
    $display("cycle %s req=%b led=%b busy=%b ack=%b", tag, req, led, busy, hit_ack);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", OFF, 1'b0, 1'b0);
    rst_n = 1'b1;

    // ---- vector table ----
    // hit_req in IDLE is ignored
    add(R_HIT,   1, OFF,      1'b0, 1'b0);
    add(R_NONE,  2, OFF,      1'b0, 1'b0);
    // sweep: 0,1,2,3,4,3,2,1,0,1,... each held 4 cycles
    add(R_START, 4, 5'b00001, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b00010, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b00100, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b01000, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b10000, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b01000, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b00100, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b00010, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b00001, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b00010, 1'b1, 1'b0);
    // hit mid-position while led=00100 going up; 24-cycle flash with a
    // second hit_req that must be ignored
    add(R_NONE,  2, 5'b00100, 1'b1, 1'b0);
    add(R_HIT,   1, ALL,      1'b1, 1'b1);
    add(R_NONE,  3, ALL,      1'b1, 1'b0);
    add(R_HIT,   4, OFF,      1'b1, 1'b0);
    add(R_NONE,  4, ALL,      1'b1, 1'b0);
    add(R_START, 4, OFF,      1'b1, 1'b0);
    add(R_NONE,  4, ALL,      1'b1, 1'b0);
    add(R_NONE,  4, OFF,      1'b1, 1'b0);
    add(R_NONE,  4, 5'b00100, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b01000, 1'b1, 1'b0);
    // start during SWEEP does not restart the sweep
    add(R_START, 4, 5'b10000, 1'b1, 1'b0);
    add(R_NONE,  4, 5'b01000, 1'b1, 1'b0);
    // stop + ko together: stop wins
    add(R_STOP | R_KO, 1, OFF, 1'b0, 1'b0);
    add(R_NONE,  3, OFF,      1'b0, 1'b0);
    // ko + hit together in SWEEP: KO, no ack
    add(R_START, 4, 5'b00001, 1'b1, 1'b0);
    add(R_NONE,  2, 5'b00010, 1'b1, 1'b0);
    add(R_KO | R_HIT, 3, ALL, 1'b1, 1'b0);
    add(R_STOP,  2, OFF,      1'b0, 1'b0);
    // ko_req in IDLE is ignored
    add(R_KO,    2, OFF,      1'b0, 1'b0);
    // ko during the off phase of a flash
    add(R_START, 4, 5'b00001, 1'b1, 1'b0);
    add(R_HIT,   1, ALL,      1'b1, 1'b1);
    add(R_NONE,  3, ALL,      1'b1, 1'b0);
    add(R_NONE,  2, OFF,      1'b1, 1'b0);
    add(R_KO,    4, ALL,      1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        drive_cycle((c == 0) ? vecs[i].req : R_NONE, vecs[i].led, vecs[i].busy,
                    vecs[i].ack, $sformatf("vec%0d.%0d", i, c));
      end
    end

    // ---- KO latch: 100 cycles of stray hit/start pulses ----
    for (int k = 0; k < 100; k++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 3)) & (R_HIT | R_START);
      drive_cycle(r, ALL, 1'b1, 1'b0, $sformatf("ko_hold.%0d", k));
    end
    drive_cycle(R_STOP, OFF, 1'b0, 1'b0, "ko_stop");

    // ---- asynchronous reset in the middle of a flash ----
    drive_cycle(R_START, 5'b00001, 1'b1, 1'b0, "ar_start");
    for (int k = 0; k < 3; k++) drive_cycle(R_NONE, 5'b00001, 1'b1, 1'b0, $sformatf("ar_sw.%0d", k));
    drive_cycle(R_HIT, ALL, 1'b1, 1'b1, "ar_hit");
    for (int k = 0; k < 5; k++) begin
      drive_cycle(R_NONE, (k < 3) ? ALL : OFF, 1'b1, 1'b0, $sformatf("ar_fl.%0d", k));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", OFF, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) drive_cycle(R_NONE, OFF, 1'b0, 1'b0, $sformatf("ar_idle.%0d", k));
    drive_cycle(R_START, 5'b00001, 1'b1, 1'b0, "ar_restart");
    for (int k = 0; k < 3; k++) drive_cycle(R_NONE, 5'b00001, 1'b1, 1'b0, $sformatf("ar_p0.%0d", k));
    drive_cycle(R_NONE, 5'b00010, 1'b1, 1'b0, "ar_p1");

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Mode controller for the 5-LED ring/bar on the boxing board. It sequences the LED pattern between four modes:
- idle (dark)
- sweep (a single lit LED bouncing end to end at a divided rate)
- hit flash (the whole bar blinks a fixed number of times, then the sweep resumes where it left off)
- KO (the whole bar lit steadily)

Game logic drives it with single-cycle event requests. It arbitrates simultaneous requests by fixed priority.

## Interface
Parameters:
- STEP_DIV, default 4: clock cycles each sweep position is held; legal range ≥1.
- FLASH_DIV, default 4: clock cycles per flash half-period (on or off); legal range ≥1.
- FLASH_COUNT, default 3: number of on/off blink pairs per hit; legal range ≥1.

Ports:
- clk, input, 1: single system clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: pulse; begins a sweep from IDLE.
- stop, input, 1: pulse; returns to IDLE from any state.
- hit_req, input, 1: pulse; requests a hit flash.
- ko_req, input, 1: pulse; requests KO display.
- led, output, 5: LED drive; bit 0 is the first LED.
- busy, output, 1: high in any state other than IDLE.
- hit_ack, output, 1: one-cycle pulse when a hit_req is accepted.

## Operation
- States: IDLE, SWEEP, FLASH, KO.
- Saved sweep context: position pos (0..4) and direction dir (up/down).
- Request priority, evaluated every cycle: stop > ko_req > hit_req > start. Only the highest-priority request that applies in the current state acts; all others in that cycle are dropped, not queued.
- IDLE:
  - led = 00000.
  - start → SWEEP with pos = 0, dir = up.
  - hit_req is ignored (no ack).
- SWEEP:
  - led is one-hot at pos.
  - Every STEP_DIV cycles pos advances by one in direction dir.
  - Bounce: at pos 4 with dir up, the next step goes to 3 and dir becomes down. At pos 0 with dir down, the next step goes to 1 and dir becomes up.
  - Position sequence: 0,1,2,3,4,3,2,1,0,1,…
  - start is ignored in SWEEP.
- FLASH:
  - Entered from SWEEP on hit_req; hit_ack pulses in the same cycle the state becomes FLASH.
  - led = 11111 for FLASH_DIV cycles, then 00000 for FLASH_DIV cycles, repeated FLASH_COUNT times.
  - Then returns to SWEEP with the saved pos/dir and the step divider cleared.
  - hit_req and start are ignored (no ack, no restart of the flash).
- KO:
  - ko_req from SWEEP or FLASH → KO. Any in-progress flash is abandoned.
  - led = 11111.
  - Only stop exits KO. ko_req in IDLE is ignored.
- stop from any state → IDLE; sweep context is cleared.
- Internal counters:
  - Step/flash divider width is $clog2(max(STEP_DIV, FLASH_DIV)) + 1.
  - Flash phase counter counts 0 to 2·FLASH_COUNT−1.
  - Both counters wrap to 0 on every state entry.

## Timing
- Reset values (asynchronous, rst_n low): state IDLE, led 00000, busy 0, hit_ack 0, pos 0, dir up, all counters 0.
- Outputs are registered. A request sampled on edge N is visible on led/busy/hit_ack after edge N.
- SWEEP entry: led = 00001 for exactly STEP_DIV cycles, then 00010, and so on. Each position lasts exactly STEP_DIV cycles, including the end positions 0 and 4 (no double dwell at the ends).
- FLASH duration is exactly 2·FLASH_COUNT·FLASH_DIV cycles. The first SWEEP cycle afterwards shows the saved position, which is then held for a full STEP_DIV cycles.
- hit_ack is high for exactly one cycle per accepted hit and never asserted outside the FLASH-entry cycle.
- Reset asserted mid-sweep or mid-flash: outputs go to reset values immediately (asynchronously); operation restarts only on a new start.

## Structure
- Package led_seq_pkg holds:
  - the state enum (IDLE, SWEEP, FLASH, KO)
  - LED_W = 5
  - pattern constants LED_OFF = 00000 and LED_ALL = 11111
- One sub-module, tick_divider: a parameterised prescaler with a synchronous clear input and a one-cycle tick output. It is instantiated once and shared by SWEEP and FLASH. The divide value is muxed by state.
- Remaining logic: one FSM block plus the pos/dir/flash-counter registers.

## Test plan
- Reset then sweep (defaults): release rst_n, pulse start at cycle 0 → led 00001 over cycles 1–4, 00010 over 5–8, 10000 over 17–20, 01000 over 21–24, 00001 over 33–36, then 00010; busy = 1 from cycle 1.
- Hit mid-sweep: pulse hit_req while led = 00100 with dir up → hit_ack high for exactly 1 cycle; led alternates 11111/00000 every 4 cycles for 24 cycles; then 00100 for 4 cycles, then 01000.
- Ignored requests: hit_req in IDLE, and a second hit_req during FLASH → no hit_ack, no change in flash length. start during SWEEP → pos unchanged.
- Priority: stop and ko_req in the same cycle during SWEEP → IDLE, led 00000, busy 0. ko_req and hit_req together → KO, led 11111, no hit_ack.
- KO latch: ko_req during FLASH → led 11111 steady for 100 cycles despite further hit_req/start pulses; stop → IDLE next cycle.
- Async reset mid-flash: drop rst_n between clock edges → led 00000, busy 0 immediately; after release, led stays 00000 until start.
